// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings and sizing helper.
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL/core-side signal bundle of the reset sequencer; master is the sequencer itself.
interface pll_reset_sequencer_if;
    import pll_seq_pkg::*;

    logic               pll_lock;
    logic               restart;
    logic               pll_resetb;
    logic               sys_reset;
    logic               pll_ready;
    logic               fault;
    logic [7:0]         lock_loss_count;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  pll_lock, restart,
        output pll_resetb, sys_reset, pll_ready, fault, lock_loss_count, state_dbg
    );

    modport slave (
        output pll_lock, restart,
        input  pll_resetb, sys_reset, pll_ready, fault, lock_loss_count, state_dbg
    );

endinterface

// File: rtl/pll_reset_sequencer_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL RESETB and the core-domain reset from the reference clock,
// with lock qualification, bounded retries and a latched fault state.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pll_reset_sequencer_if.master bus
);

    localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES + 1) ? CNT_MAX_A : LOCK_STABLE_CYCLES + 1;
    localparam int CNT_W     = clog2(CNT_MAX);
    localparam int RTY_W     = clog2(MAX_RETRIES) + 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_DONE = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [7:0]         llc_q, llc_d;
    logic               lock_s;
    logic               loss_evt;
    logic               pll_resetb_q, pll_resetb_d;
    logic               sys_reset_q, sys_reset_d;
    logic               pll_ready_q, pll_ready_d;
    logic               fault_q, fault_d;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PLL_RESET;
            cnt_q        <= '0;
            retry_q      <= '0;
            llc_q        <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            pll_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            llc_q        <= llc_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            pll_ready_q  <= pll_ready_d;
            fault_q      <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        loss_evt = 1'b0;
        case (state_q)
            PLL_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Lock seen on the timeout cycle still counts as a lock.
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RTY_LAST) begin
                        state_d = FAULT;
                    end else begin
                        state_d = PLL_RESET;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STB_DONE) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = PLL_RESET;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RESET;
                cnt_d   = '0;
            end
        endcase
        // Restart overrides everything but leaves the lock-loss history intact.
        if (bus.restart) begin
            state_d = PLL_RESET;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    always_comb begin
        pll_resetb_d = !((state_d == PLL_RESET) || (state_d == FAULT));
        sys_reset_d  = (state_d != RUN);
        pll_ready_d  = (state_d == RUN);
        fault_d      = (state_d == FAULT);
        llc_d        = (loss_evt && (llc_q != 8'hFF)) ? llc_q + 8'd1 : llc_q;
    end

    assign bus.pll_resetb      = pll_resetb_q;
    assign bus.sys_reset       = sys_reset_q;
    assign bus.pll_ready       = pll_ready_q;
    assign bus.fault           = fault_q;
    assign bus.lock_loss_count = llc_q;
    assign bus.state_dbg       = state_q;

endmodule
